// File: rtl/mem_line_assembler.sv
// Assembles BEATS external memory beats into one cache line, delivered through a holding register.
// Optional sticky lost-beat flag: define MEM_LINE_ASM_OVERRUN_EN.
module mem_line_assembler #(
  parameter int EXT_W = 40,
  parameter int BEATS = 2
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [EXT_W-1:0]         i_mem_data,
  input  logic                     i_mem_data_valid,
  output logic                     o_ready,
  input  logic                     i_halt,
  input  logic                     i_flush,
  output logic [EXT_W*BEATS-1:0]   o_mem_data,
  output logic                     o_mem_data_valid,
  input  logic                     i_line_ready,
  output logic                     o_overrun
);

  localparam int INT_W = EXT_W * BEATS;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {FILL, STALL} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [INT_W-1:0]   asm_q, asm_d;
  logic [INT_W-1:0]   hold_q, hold_d;
  logic               hvalid_q, hvalid_d;
  logic [INT_W-1:0]   asm_merged;
  logic               acc;
  logic               last;
  logic               hfree;

  assign o_ready = ~i_halt & ~i_flush & (state_q == FILL);
  assign acc     = i_mem_data_valid & o_ready;
  assign last    = (cnt_q == CNT_W'(BEATS - 1));
  assign hfree   = ~hvalid_q | i_line_ready;

  // Assembly register with the current beat dropped into the slot the counter points at.
  always_comb begin
    asm_merged = asm_q;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        asm_merged[k*EXT_W +: EXT_W] = i_mem_data;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    hold_d   = hold_q;
    hvalid_d = hvalid_q;
    if (hvalid_q & i_line_ready) begin
      hvalid_d = 1'b0;
    end
    // Flush only throws away the partial or pending line; the holding register is left alone.
    if (i_flush) begin
      cnt_d   = '0;
      state_d = FILL;
    end else if (state_q == STALL) begin
      if (hfree) begin
        hold_d   = asm_q;
        hvalid_d = 1'b1;
        state_d  = FILL;
      end
    end else if (acc) begin
      asm_d = asm_merged;
      if (last) begin
        cnt_d = '0;
        if (hfree) begin
          hold_d   = asm_merged;
          hvalid_d = 1'b1;
        end else begin
          state_d = STALL;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      asm_q    <= '0;
      hold_q   <= '0;
      hvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      hold_q   <= hold_d;
      hvalid_q <= hvalid_d;
    end
  end

  assign o_mem_data       = hold_q;
  assign o_mem_data_valid = hvalid_q;

`ifdef MEM_LINE_ASM_OVERRUN_EN
  logic ovr_q;

  // A beat offered while not ready is lost, unless it was deliberately flushed.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ovr_q <= 1'b0;
    end else if (i_flush) begin
      ovr_q <= 1'b0;
    end else if (i_mem_data_valid & ~o_ready) begin
      ovr_q <= 1'b1;
    end
  end

  assign o_overrun = ovr_q;
`else
  assign o_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_mem_line_assembler.sv
// Self-checking bench for mem_line_assembler: a BEATS=2 and a BEATS=4 instance share one input stream
// and are compared every cycle against a beat-list reference model, plus directed line checks.
module tb_mem_line_assembler;

`ifdef MEM_LINE_ASM_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic          clk;
  logic          arst_n;
  logic [39:0]   memData;
  logic          memValid;
  logic          halt;
  logic          flush;
  logic          lineReady;

  logic          readyA, validA, ovrA;
  logic [79:0]   dataA;
  logic          readyB, validB, ovrB;
  logic [159:0]  dataB;

  int passCount = 0;
  int failCount = 0;
  int totalCount = 0;

  // Reference model state, index 0 = BEATS 2 instance, index 1 = BEATS 4 instance
  int            partCnt[2];
  logic [39:0]   partBeats[2][4];
  logic [159:0]  pendLine[2];
  bit            pendValid[2];
  logic [159:0]  holdLine[2];
  bit            holdValid[2];
  bit            ovr[2];

  mem_line_assembler #(.EXT_W(40), .BEATS(2)) dutA (
    .clk(clk), .arst_n(arst_n),
    .i_mem_data(memData), .i_mem_data_valid(memValid), .o_ready(readyA),
    .i_halt(halt), .i_flush(flush),
    .o_mem_data(dataA), .o_mem_data_valid(validA), .i_line_ready(lineReady),
    .o_overrun(ovrA)
  );

  mem_line_assembler #(.EXT_W(40), .BEATS(4)) dutB (
    .clk(clk), .arst_n(arst_n),
    .i_mem_data(memData), .i_mem_data_valid(memValid), .o_ready(readyB),
    .i_halt(halt), .i_flush(flush),
    .o_mem_data(dataB), .o_mem_data_valid(validB), .i_line_ready(lineReady),
    .o_overrun(ovrB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] observed, input logic [159:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int m = 0; m < 2; m++) begin
      partCnt[m]   = 0;
      pendLine[m]  = '0;
      pendValid[m] = 1'b0;
      holdLine[m]  = '0;
      holdValid[m] = 1'b0;
      ovr[m]       = 1'b0;
    end
  endtask

  function automatic bit expReady(input int m);
    return !halt && !flush && !pendValid[m];
  endfunction

  // Advance one model by one clock, using the inputs currently driven.
  task automatic modelStep(input int m);
    int nb;
    bit rdy;
    bit hfree;
    logic [159:0] line;
    nb    = (m == 0) ? 2 : 4;
    rdy   = expReady(m);
    hfree = !holdValid[m] || lineReady;
    if (OVR_EN) begin
      if (flush) ovr[m] = 1'b0;
      else if (memValid && !rdy) ovr[m] = 1'b1;
    end
    if (holdValid[m] && lineReady) holdValid[m] = 1'b0;
    if (pendValid[m]) begin
      if (flush) pendValid[m] = 1'b0;
      else if (hfree) begin
        holdLine[m]  = pendLine[m];
        holdValid[m] = 1'b1;
        pendValid[m] = 1'b0;
      end
    end else if (flush) begin
      partCnt[m] = 0;
    end else if (memValid && rdy) begin
      partBeats[m][partCnt[m]] = memData;
      partCnt[m]++;
      if (partCnt[m] == nb) begin
        line = '0;
        for (int k = 0; k < nb; k++) line[k*40 +: 40] = partBeats[m][k];
        partCnt[m] = 0;
        if (hfree) begin
          holdLine[m]  = line;
          holdValid[m] = 1'b1;
        end else begin
          pendLine[m]  = line;
          pendValid[m] = 1'b1;
        end
      end
    end
  endtask

  task automatic checkOutput();
    check("A_ready", 160'(readyA), 160'(expReady(0)));
    check("A_valid", 160'(validA), 160'(holdValid[0]));
    check("A_data",  {80'b0, dataA}, holdLine[0]);
    check("A_ovr",   160'(ovrA),   160'(ovr[0]));
    check("B_ready", 160'(readyB), 160'(expReady(1)));
    check("B_valid", 160'(validB), 160'(holdValid[1]));
    check("B_data",  dataB,        holdLine[1]);
    check("B_ovr",   160'(ovrB),   160'(ovr[1]));
  endtask

  // One clock: drive inputs after the falling edge, check, then let the model take the rising edge.
  task automatic applyStimulus(input logic v, input logic [39:0] d, input logic h,
                               input logic f, input logic lr);
    @(negedge clk);
    memValid  = v;
    memData   = d;
    halt      = h;
    flush     = f;
    lineReady = lr;
    #1;
    checkOutput();
    modelStep(0);
    modelStep(1);
  endtask

  task automatic realign();
    applyStimulus(1'b0, 40'h0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    memValid  = 1'b0;
    memData   = '0;
    halt      = 1'b0;
    flush     = 1'b0;
    lineReady = 1'b1;
    arst_n    = 1'b1;
    modelReset();
    #1 arst_n = 1'b0;
    repeat (2) @(negedge clk);
    arst_n = 1'b1;

    // Two-beat line with an always-ready consumer
    applyStimulus(1'b1, 40'hAAAAAAAAAA, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 40'h5555555555, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b1);
    check("t1_line",  {80'b0, dataA}, {80'b0, 80'h5555555555_AAAAAAAAAA});
    check("t1_valid", 160'(validA), 160'(1));
    applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b1);
    check("t1_pulse", 160'(validA), 160'(0));
    realign();

    // Stalled consumer: eight beats fill the holding register and then the assembly register
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 40'(i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b0);
    check("t2_stall_ready", 160'(readyB), 160'(0));
    check("t2_line1", dataB, {40'd4, 40'd3, 40'd2, 40'd1});
    applyStimulus(1'b1, 40'h99, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b1);
    check("t2_ovr_set", 160'(ovrB), 160'(OVR_EN));
    applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b0);
    check("t2_line2", dataB, {40'd8, 40'd7, 40'd6, 40'd5});
    check("t2_ready_back", 160'(readyB), 160'(1));
    check("t2_ovr_sticky", 160'(ovrB), 160'(OVR_EN));
    realign();
    check("t2_ovr_clear", 160'(ovrB), 160'(0));

    // Halt freezes capture with the partial line held
    applyStimulus(1'b1, 40'h11, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 40'h99, 1'b1, 1'b0, 1'b1);
      check("t3_halt_ready", 160'(readyA), 160'(0));
    end
    applyStimulus(1'b1, 40'h22, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b1);
    check("t3_line", {80'b0, dataA}, {80'b0, 40'h22, 40'h11});
    realign();

    // Flush mid-line leaves no stale beats behind
    applyStimulus(1'b1, 40'h77, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 40'h88, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 40'h66, 1'b0, 1'b1, 1'b1);
    for (int i = 10; i <= 13; i++) applyStimulus(1'b1, 40'(i), 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b1);
    check("t4_line", dataB, {40'hD, 40'hC, 40'hB, 40'hA});
    realign();

    // Asynchronous reset while a line is pending in STALL
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 40'(i + 32), 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    memValid = 1'b0;
    arst_n   = 1'b0;
    #1;
    check("t5_rst_valid", 160'(validB), 160'(0));
    check("t5_rst_data",  dataB, 160'(0));
    check("t5_rst_validA", 160'(validA), 160'(0));
    modelReset();
    @(negedge clk);
    arst_n = 1'b1;
    applyStimulus(1'b0, 40'h0, 1'b0, 1'b0, 1'b0);
    check("t5_ready_after", 160'(readyB), 160'(1));

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) < 7), {8'($urandom), $urandom},
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
